// File: rtl/keylock_controller.sv
// ============================================================================
//  Module   : keylock_controller
//  Purpose  : Keypad keylock sequencer. It gates the digit accumulator, checks
//             the submitted code and runs the unlock window and the lockout.
//  Option   : KEYLOCK_ENTRY_TIMEOUT_EN adds an idle auto-clear while in ENTRY.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keylock_controller #(
  parameter logic [31:0] CODE                 = 32'd1234,
  parameter int          MAX_TRIES            = 3,
  parameter int          UNLOCK_CYCLES        = 60000000,
  parameter int          LOCKOUT_CYCLES       = 120000000,
  parameter int          ENTRY_TIMEOUT_CYCLES = 120000000,
  parameter int          KEY_ENTER            = 7,
  parameter int          KEY_CLEAR            = 8
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic        button_pressed,
  input  logic [7:0]  key,
  input  logic [31:0] typed,
  output logic        entry_enable,
  output logic        unlocked,
  output logic        locked_out,
  output logic [3:0]  fail_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int         MAX_CYC     = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int         TMR_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [3:0] MAX_TRIES_L = 4'(MAX_TRIES);
  localparam logic [7:0] KEY_ENT_L   = 8'(KEY_ENTER);
  localparam logic [7:0] KEY_CLR_L   = 8'(KEY_CLEAR);

  state_t             state_q, state_d;
  logic [3:0]         fail_q, fail_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               btn_q;
  logic               press_edge;
  logic [3:0]         fail_inc;

  assign press_edge = button_pressed & ~btn_q;
  assign fail_inc   = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
  localparam int IDLE_W = (ENTRY_TIMEOUT_CYCLES > 1) ? $clog2(ENTRY_TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_ff @(posedge hwclk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (ENTRY_TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      fail_q  <= 4'd0;
      tmr_q   <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      btn_q   <= button_pressed;
    end
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
    idle_d  = '0;
`endif
    case (state_q)
      ST_CLEAR: state_d = ST_ENTRY;
      ST_ENTRY: begin
        if (press_edge && key == KEY_ENT_L) begin
          state_d = ST_CHECK;
        end else if (press_edge && key == KEY_CLR_L) begin
          state_d = ST_CLEAR;
`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
        end else if (!press_edge) begin
          // Idle cycles since the last press; expiry discards the entry.
          if (idle_q == IDLE_W'(ENTRY_TIMEOUT_CYCLES - 1)) state_d = ST_CLEAR;
          else                                            idle_d  = idle_q + 1'b1;
`endif
        end
      end
      ST_CHECK: begin
        if (typed == CODE) begin
          state_d = ST_OPEN;
          fail_d  = 4'd0;
          tmr_d   = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          fail_d = fail_inc;
          if (fail_inc >= MAX_TRIES_L) begin
            state_d = ST_LOCKOUT;
            tmr_d   = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_OPEN: begin
        // Timer loaded with N-1 so the state is held for exactly N cycles.
        if (press_edge && key == KEY_ENT_L) state_d = ST_CLEAR;
        else if (tmr_q == '0)               state_d = ST_CLEAR;
        else                                tmr_d   = tmr_q - 1'b1;
      end
      ST_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = ST_CLEAR;
          fail_d  = 4'd0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign entry_enable = (state_q == ST_ENTRY) || (state_q == ST_CHECK);
  assign unlocked     = (state_q == ST_OPEN);
  assign locked_out   = (state_q == ST_LOCKOUT);
  assign fail_count   = fail_q;
  assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_keylock_controller.sv
// ============================================================================
//  Module   : tb_keylock_controller
//  Purpose  : Scoreboard bench for keylock_controller with a keyList model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keylock_controller;

  localparam int CODE      = 1234;
  localparam int MAX_TRIES = 3;
  localparam int UNLOCK_N  = 20;
  localparam int LOCK_N    = 50;
  localparam int TIMEOUT_N = 30;

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic        button_pressed = 1'b0;
  logic [7:0]  key = 8'd0;
  logic [31:0] typed;
  logic        entry_enable, unlocked, locked_out;
  logic [3:0]  fail_count;
  logic [2:0]  state;

  keylock_controller #(
    .CODE(32'(CODE)), .MAX_TRIES(MAX_TRIES), .UNLOCK_CYCLES(UNLOCK_N),
    .LOCKOUT_CYCLES(LOCK_N), .ENTRY_TIMEOUT_CYCLES(TIMEOUT_N),
    .KEY_ENTER(7), .KEY_CLEAR(8)
  ) dut (
    .hwclk(hwclk), .reset(reset), .button_pressed(button_pressed), .key(key),
    .typed(typed), .entry_enable(entry_enable), .unlocked(unlocked),
    .locked_out(locked_out), .fail_count(fail_count), .state(state)
  );

  always #5 hwclk = ~hwclk;

  // Decimal digit accumulator standing in for keyList.
  logic btn_prev;
  always @(posedge hwclk) begin
    btn_prev <= button_pressed;
    if (reset || !entry_enable) typed <= 32'd0;
    else if (button_pressed && !btn_prev && key < 8'd10 && key != 8'd7 && key != 8'd8)
      typed <= typed * 32'd10 + 32'(key);
  end

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  fc;
    logic [31:0] typed;
  } exp_t;

  exp_t exp_q[$];
  int   open_len_q[$];
  int   lock_len_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic press(input int k);
    button_pressed = 1'b1;
    key = 8'(k);
    tick(2);
    button_pressed = 1'b0;
    tick(2);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (state !== s && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic push_expect(input int val, input int open_len, input int lock_len);
    exp_t e;
    e.typed = 32'(val);
    if (val == CODE) begin
      exp_fail = 0;
      e.st = 3'd3;
      if (open_len > 0) open_len_q.push_back(open_len);
    end else begin
      if (exp_fail < 15) exp_fail++;
      e.st = (exp_fail >= MAX_TRIES) ? 3'd4 : 3'd0;
      if (e.st == 3'd4 && lock_len > 0) lock_len_q.push_back(lock_len);
    end
    e.fc = 4'(exp_fail);
    exp_q.push_back(e);
  endtask

  task automatic submit(input int a, input int b, input int c, input int d,
                        input int open_len, input int lock_len);
    wait_state(3'd1, 80, "ready_for_entry");
    press(a); press(b); press(c); press(d);
    push_expect(a * 1000 + b * 100 + c * 10 + d, open_len, lock_len);
    press(7);
  endtask

  // Output monitor: pops scoreboard at CHECK and measures OPEN/LOCKOUT spans.
  initial begin
    exp_t       cur;
    bit         pend = 1'b0;
    int         open_run = 0;
    int         lock_run = 0;
    logic [2:0] prev_state = 3'd7;
    logic       prev_rst = 1'b1;
    forever begin
      @(negedge hwclk);
      if (pend) begin
        chk("post_check_state", 32'(state), 32'(cur.st));
        chk("post_check_fail_count", 32'(fail_count), 32'(cur.fc));
        pend = 1'b0;
      end
      if (!reset && state === 3'd2) begin
        if (exp_q.size() == 0) chk("unexpected_check", 32'd1, 32'd0);
        else begin
          cur = exp_q.pop_front();
          chk("check_typed", typed, cur.typed);
          pend = 1'b1;
        end
      end
      if (!reset && !prev_rst && prev_state === 3'd0)
        chk("clear_one_cycle", 32'(state), 32'd1);
      if (unlocked === 1'b1) open_run++;
      else begin
        if (open_run > 0 && !reset) begin
          if (open_len_q.size() == 0) chk("unexpected_open", 32'(open_run), 32'd0);
          else chk("open_length", 32'(open_run), 32'(open_len_q.pop_front()));
        end
        open_run = 0;
      end
      if (locked_out === 1'b1) lock_run++;
      else begin
        if (lock_run > 0 && !reset) begin
          if (lock_len_q.size() == 0) chk("unexpected_lockout", 32'(lock_run), 32'd0);
          else chk("lockout_length", 32'(lock_run), 32'(lock_len_q.pop_front()));
        end
        lock_run = 0;
      end
      prev_state = state;
      prev_rst   = reset;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_entry_enable", 32'(entry_enable), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_locked_out", 32'(locked_out), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    reset = 1'b0;
    chk("release_state", 32'(state), 32'd0);
    tick(1);
    chk("post_rst_state", 32'(state), 32'd1);
    chk("post_rst_entry_enable", 32'(entry_enable), 32'd1);

    // 2: correct code, full unlock window
    submit(1, 2, 3, 4, UNLOCK_N, 0);
    chk("open_unlocked", 32'(unlocked), 32'd1);
    chk("open_entry_enable", 32'(entry_enable), 32'd0);
    wait_state(3'd1, 60, "open_expiry");
    chk("open_fail_count", 32'(fail_count), 32'd0);

    // 3: three failures then lockout; presses inside lockout ignored
    submit(1, 2, 3, 5, 0, LOCK_N);
    submit(1, 2, 3, 5, 0, LOCK_N);
    submit(1, 2, 3, 5, 0, LOCK_N);
    chk("lockout_flag", 32'(locked_out), 32'd1);
    press(1); press(2); press(3); press(4); press(7);
    chk("lockout_no_unlock", 32'(unlocked), 32'd0);
    chk("lockout_still", 32'(state), 32'd4);
    wait_state(3'd1, 80, "lockout_expiry");
    chk("lockout_fail_cleared", 32'(fail_count), 32'd0);
    exp_fail = 0;

    // 4: CLEAR key mid-entry, then wrong remainder
    wait_state(3'd1, 80, "ready_for_entry");
    press(1); press(2); press(8);
    chk("clear_key_typed", typed, 32'd0);
    press(3); press(4);
    push_expect(34, 0, 0);
    press(7);
    chk("clear_key_not_unlocked", 32'(unlocked), 32'd0);

    // 5: early relock, then unlock again
    submit(1, 2, 3, 4, 5, 0);
    tick(2);
    button_pressed = 1'b1;
    key = 8'd7;
    chk("relock_before_edge", 32'(unlocked), 32'd1);
    tick(1);
    chk("relock_unlocked", 32'(unlocked), 32'd0);
    chk("relock_state", 32'(state), 32'd0);
    tick(1);
    button_pressed = 1'b0;
    tick(2);
    submit(1, 2, 3, 4, UNLOCK_N, 0);
    wait_state(3'd1, 60, "second_open_expiry");

    // 6: reset in the middle of lockout
    submit(9, 9, 9, 9, 0, 0);
    submit(0, 0, 0, 0, 0, 0);
    submit(4, 3, 2, 1, 0, 0);
    tick(10);
    chk("pre_reset_lockout", 32'(locked_out), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("mid_lock_rst_state", 32'(state), 32'd0);
    chk("mid_lock_rst_locked_out", 32'(locked_out), 32'd0);
    chk("mid_lock_rst_fail_count", 32'(fail_count), 32'd0);
    tick(1);
    reset = 1'b0;
    exp_fail = 0;

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
    submit(1, 2, 3, 5, 0, 0);
    wait_state(3'd1, 80, "ready_for_timeout");
    press(1);
    chk("timeout_typed_before", typed, 32'd1);
    tick(32);
    chk("timeout_state", 32'(state), 32'd1);
    chk("timeout_typed_cleared", typed, 32'd0);
    chk("timeout_fail_kept", 32'(fail_count), 32'd1);
`endif

    tick(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("open_lengths_drained", 32'(open_len_q.size()), 32'd0);
    chk("lock_lengths_drained", 32'(lock_len_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
